// File: rtl/ps2_host_tx.sv
// ps2_host_tx: host-to-device PS/2 command transmitter.
// Pulls the clock low to inhibit the device, issues a request-to-send, then
// shifts a 10-bit frame (8 data LSB first, odd parity, stop) out on the
// device-generated clock and checks the device's ack bit.
// Optional feature macro: PS2_TX_RETRY_EN (re-send a failed frame up to
// MAX_RETRIES extra times before reporting tx_err).
// Ports:
//   clk, rst                 system clock, async active-high reset
//   ps2_clk_in, ps2_data_in  raw PS/2 line levels
//   ps2_clk_oe, ps2_data_oe  1 = pull line low, 0 = release
//   tx_data, tx_valid        command byte and send request
//   tx_ready                 high only while idle
//   tx_busy                  high while a frame is in flight
//   tx_done, tx_err          one-cycle completion / failure pulses
module ps2_host_tx #(
  parameter int unsigned INHIBIT_CYCLES = 5000,
  parameter int unsigned TIMEOUT_CYCLES = 750000,
  parameter int unsigned MAX_RETRIES    = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       ps2_clk_in,
  input  logic       ps2_data_in,
  output logic       ps2_clk_oe,
  output logic       ps2_data_oe,
  input  logic [7:0] tx_data,
  input  logic       tx_valid,
  output logic       tx_ready,
  output logic       tx_busy,
  output logic       tx_done,
  output logic       tx_err
);

`ifdef PS2_TX_RETRY_EN
  localparam int unsigned RETRY_LIMIT = MAX_RETRIES;
`else
  // Retries disabled in this build: the first failure is final.
  localparam int unsigned RETRY_LIMIT = MAX_RETRIES * 0;
`endif

  localparam int unsigned WD_W  = $clog2(TIMEOUT_CYCLES + 1);
  localparam int unsigned INH_W = (INHIBIT_CYCLES > 1) ? $clog2(INHIBIT_CYCLES) : 1;
  localparam int unsigned RTR_W = (RETRY_LIMIT > 0) ? $clog2(RETRY_LIMIT + 1) : 1;

  localparam logic [2:0] S_IDLE      = 3'd0;
  localparam logic [2:0] S_INHIBIT   = 3'd1;
  localparam logic [2:0] S_REQ       = 3'd2;
  localparam logic [2:0] S_SEND      = 3'd3;
  localparam logic [2:0] S_ACK       = 3'd4;
  localparam logic [2:0] S_IDLE_WAIT = 3'd5;

  logic [2:0]       state, state_n;
  logic [INH_W-1:0] inh_cnt, inh_cnt_n;
  logic [WD_W-1:0]  wd_cnt, wd_cnt_n;
  logic [3:0]       bit_idx, bit_idx_n;
  logic [9:0]       frame, frame_n;
  logic [RTR_W-1:0] retry_cnt, retry_cnt_n;
  logic             clk_oe_n, data_oe_n, ready_n, busy_n, done_n, err_n;
  logic             clk_s1, clk_s2, clk_prev, data_s1, data_s2;
  logic             fall, wd_expired, fail;

  // Two-flop synchronizers plus previous-clock flop for edge detection
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      clk_s1   <= 1'b1;
      clk_s2   <= 1'b1;
      clk_prev <= 1'b1;
      data_s1  <= 1'b1;
      data_s2  <= 1'b1;
    end else begin
      clk_s1   <= ps2_clk_in;
      clk_s2   <= clk_s1;
      clk_prev <= clk_s2;
      data_s1  <= ps2_data_in;
      data_s2  <= data_s1;
    end
  end

  assign fall       = clk_prev & ~clk_s2;
  assign wd_expired = (wd_cnt == WD_W'(TIMEOUT_CYCLES - 1));

  // State and registered outputs
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= S_IDLE;
      inh_cnt     <= '0;
      wd_cnt      <= '0;
      bit_idx     <= '0;
      frame       <= '0;
      retry_cnt   <= '0;
      ps2_clk_oe  <= 1'b0;
      ps2_data_oe <= 1'b0;
      tx_ready    <= 1'b1;
      tx_busy     <= 1'b0;
      tx_done     <= 1'b0;
      tx_err      <= 1'b0;
    end else begin
      state       <= state_n;
      inh_cnt     <= inh_cnt_n;
      wd_cnt      <= wd_cnt_n;
      bit_idx     <= bit_idx_n;
      frame       <= frame_n;
      retry_cnt   <= retry_cnt_n;
      ps2_clk_oe  <= clk_oe_n;
      ps2_data_oe <= data_oe_n;
      tx_ready    <= ready_n;
      tx_busy     <= busy_n;
      tx_done     <= done_n;
      tx_err      <= err_n;
    end
  end

  // Next-state and next-output logic
  always_comb begin
    state_n     = state;
    inh_cnt_n   = inh_cnt;
    wd_cnt_n    = wd_cnt;
    bit_idx_n   = bit_idx;
    frame_n     = frame;
    retry_cnt_n = retry_cnt;
    clk_oe_n    = ps2_clk_oe;
    data_oe_n   = ps2_data_oe;
    done_n      = 1'b0;
    err_n       = 1'b0;
    fail        = 1'b0;

    case (state)
      S_IDLE: begin
        clk_oe_n  = 1'b0;
        data_oe_n = 1'b0;
        if (tx_valid && tx_ready) begin
          frame_n     = {1'b1, ~^tx_data, tx_data};
          retry_cnt_n = '0;
          inh_cnt_n   = '0;
          clk_oe_n    = 1'b1;
          state_n     = S_INHIBIT;
        end
      end
      S_INHIBIT: begin
        clk_oe_n  = 1'b1;
        data_oe_n = 1'b0;
        if (inh_cnt == INH_W'(INHIBIT_CYCLES - 1)) begin
          data_oe_n = 1'b1;
          state_n   = S_REQ;
        end else begin
          inh_cnt_n = inh_cnt + INH_W'(1);
        end
      end
      S_REQ: begin
        // Release the clock with the start bit still held low
        clk_oe_n  = 1'b0;
        data_oe_n = 1'b1;
        bit_idx_n = '0;
        wd_cnt_n  = '0;
        state_n   = S_SEND;
      end
      S_SEND: begin
        // An edge wins over a watchdog expiring on the same cycle
        if (fall) begin
          data_oe_n = ~frame[bit_idx];
          bit_idx_n = bit_idx + 4'd1;
          wd_cnt_n  = '0;
          if (bit_idx == 4'd9) begin
            data_oe_n = 1'b0;
            state_n   = S_ACK;
          end
        end else if (wd_expired) begin
          fail = 1'b1;
        end else begin
          wd_cnt_n = wd_cnt + WD_W'(1);
        end
      end
      S_ACK: begin
        if (fall) begin
          wd_cnt_n = '0;
          if (!data_s2) state_n = S_IDLE_WAIT;
          else          fail    = 1'b1;
        end else if (wd_expired) begin
          fail = 1'b1;
        end else begin
          wd_cnt_n = wd_cnt + WD_W'(1);
        end
      end
      S_IDLE_WAIT: begin
        if (clk_s2 && data_s2) begin
          done_n  = 1'b1;
          state_n = S_IDLE;
        end else if (wd_expired) begin
          fail = 1'b1;
        end else begin
          wd_cnt_n = wd_cnt + WD_W'(1);
        end
      end
      default: begin
        clk_oe_n  = 1'b0;
        data_oe_n = 1'b0;
        state_n   = S_IDLE;
      end
    endcase

    // Failure: release the lines, then either re-inhibit or report
    if (fail) begin
      clk_oe_n  = 1'b0;
      data_oe_n = 1'b0;
      if (retry_cnt != RTR_W'(RETRY_LIMIT)) begin
        retry_cnt_n = retry_cnt + RTR_W'(1);
        inh_cnt_n   = '0;
        clk_oe_n    = 1'b1;
        state_n     = S_INHIBIT;
      end else begin
        err_n   = 1'b1;
        state_n = S_IDLE;
      end
    end

    ready_n = (state_n == S_IDLE);
    busy_n  = ~ready_n;
  end

endmodule

// File: tb/tb_ps2_host_tx.sv
// tb_ps2_host_tx: randomized scoreboard bench for ps2_host_tx with a
// behavioural PS/2 device model. Expected line bits and frame outcomes are
// queued when a command is issued; monitors pop and compare them.
module tb_ps2_host_tx;
  localparam int unsigned INH = 20;
  localparam int unsigned TO  = 200;
  localparam int unsigned RTR = 2;
`ifdef PS2_TX_RETRY_EN
  localparam int ATTEMPTS = 1 + RTR;
`else
  localparam int ATTEMPTS = 1;
`endif

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       ps2_clk_in, ps2_data_in, ps2_clk_oe, ps2_data_oe;
  logic [7:0] tx_data = 8'h00;
  logic       tx_valid = 1'b0;
  logic       tx_ready, tx_busy, tx_done, tx_err;
  logic       dev_clk_low = 1'b0;
  logic       dev_data_low = 1'b0;

  int vectors = 0;
  int miscompares = 0;
  int inh_phases = 0;
  bit exp_bits[$];
  logic [1:0] exp_res[$];   // {done, err}

  assign ps2_clk_in  = ~(ps2_clk_oe | dev_clk_low);
  assign ps2_data_in = ~(ps2_data_oe | dev_data_low);

  ps2_host_tx #(.INHIBIT_CYCLES(INH), .TIMEOUT_CYCLES(TO), .MAX_RETRIES(RTR)) dut (
    .clk(clk), .rst(rst),
    .ps2_clk_in(ps2_clk_in), .ps2_data_in(ps2_data_in),
    .ps2_clk_oe(ps2_clk_oe), .ps2_data_oe(ps2_data_oe),
    .tx_data(tx_data), .tx_valid(tx_valid),
    .tx_ready(tx_ready), .tx_busy(tx_busy), .tx_done(tx_done), .tx_err(tx_err)
  );

  always #5 clk = ~clk;

  initial begin
    #800000;
    $display("FAIL global_timeout: simulation did not finish, required completion");
    $fatal(1, "global timeout");
  end

  task automatic check(input string name, input int act, input int exp);
    vectors++;
    if (act != exp) begin
      miscompares++;
      $display("FAIL %s: got %0d, required %0d", name, act, exp);
    end
  endtask

  function automatic bit odd_parity(input logic [7:0] b);
    int ones = 0;
    for (int i = 0; i < 8; i++) ones += int'(b[i]);
    return (ones % 2) == 0;
  endfunction

  // Expected line levels at each rising PS/2 clock: start, then n frame bits, then ack
  task automatic exp_push(input logic [7:0] b, input int n, input bit ack);
    exp_bits.push_back(1'b0);
    for (int i = 0; i < n; i++) begin
      if (i < 8)       exp_bits.push_back(b[i]);
      else if (i == 8) exp_bits.push_back(odd_parity(b));
      else             exp_bits.push_back(1'b1);
    end
    if (ack) exp_bits.push_back(1'b0);
  endtask

  // Line-bit monitor: the device side samples data on rising clock
  always @(posedge ps2_clk_in) begin
    if (!rst && exp_bits.size() > 0) check("line_bit", int'(ps2_data_in), int'(exp_bits.pop_front()));
  end

  // Outcome monitor
  logic prev_pulse = 1'b0;
  always @(negedge clk) begin
    if (tx_done || tx_err) begin
      check("pulse_width", int'(prev_pulse), 0);
      if (exp_res.size() == 0) check("unexpected_pulse", int'({tx_done, tx_err}), 0);
      else begin
        check("result", int'({tx_done, tx_err}), int'(exp_res.pop_front()));
        check("ready_on_pulse", int'(tx_ready), 1);
        check("lines_released", int'({ps2_clk_oe, ps2_data_oe}), 0);
      end
    end
    prev_pulse <= tx_done | tx_err;
  end

  // Inhibit-phase monitor: length of clock-only pull before each request
  int  inh_run = 0;
  bit  prev_req = 1'b0;
  always @(negedge clk) begin
    if (rst) begin
      inh_run  = 0;
      prev_req = 1'b0;
    end else begin
      if (prev_req) check("req_release", int'({ps2_clk_oe, ps2_data_oe}), 1);
      prev_req = ps2_clk_oe && ps2_data_oe;
      if (ps2_clk_oe && !ps2_data_oe) inh_run++;
      else begin
        if (ps2_clk_oe && ps2_data_oe) begin
          check("inhibit_len", inh_run, int'(INH));
          inh_phases++;
        end
        inh_run = 0;
      end
    end
  end

  task automatic wait_req(output bit ok);
    int n = 0;
    while (!ps2_clk_oe && n < 3000) begin @(negedge clk); n++; end
    while (ps2_clk_oe && n < 3000) begin @(negedge clk); n++; end
    ok = (n < 3000);
    if (!ok) check("req_seen", 0, 1);
  endtask

  task automatic dev_edge();
    repeat (20) @(negedge clk);
    dev_clk_low = 1'b1;
    repeat (20) @(negedge clk);
    dev_clk_low = 1'b0;
  endtask

  // Device model: per attempt, n clock edges; ack driven only on attempt good_on
  task automatic dev_run(input int attempts, input int n_edges, input int good_on);
    bit ok;
    for (int a = 1; a <= attempts; a++) begin
      wait_req(ok);
      if (!ok) return;
      for (int e = 0; e < n_edges; e++) dev_edge();
      if (n_edges == 10) begin
        repeat (5) @(negedge clk);
        if (a == good_on) dev_data_low = 1'b1;
        repeat (15) @(negedge clk);
        dev_clk_low = 1'b1;
        repeat (20) @(negedge clk);
        dev_clk_low = 1'b0;
        repeat (5) @(negedge clk);
        dev_data_low = 1'b0;
        if (a == good_on) return;
      end
    end
  endtask

  task automatic send(input logic [7:0] b);
    int n = 0;
    while (!tx_ready && n < 2000) begin @(negedge clk); n++; end
    tx_data  = b;
    tx_valid = 1'b1;
    @(negedge clk);
    tx_valid = 1'b0;
  endtask

  task automatic wait_results();
    int n = 0;
    while (exp_res.size() != 0 && n < 3000) begin @(negedge clk); n++; end
    check("result_arrived", exp_res.size(), 0);
    repeat (10) @(negedge clk);
    exp_bits.delete();
  endtask

  task automatic good_frame(input logic [7:0] b);
    int ph = inh_phases;
    exp_push(b, 10, 1'b1);
    exp_res.push_back(2'b10);
    send(b);
    check("busy_in_frame", int'({tx_ready, tx_busy}), 1);
    dev_run(1, 10, 1);
    wait_results();
    check("inhibit_phases", inh_phases - ph, 1);
  endtask

  initial begin
    logic [7:0] b;
    int ph, cnt;
    repeat (3) @(negedge clk);
    check("rst_ready_busy", int'({tx_ready, tx_busy}), 2);
    check("rst_oe", int'({ps2_clk_oe, ps2_data_oe}), 0);
    check("rst_pulses", int'({tx_done, tx_err}), 0);
    rst = 1'b0;
    repeat (5) @(negedge clk);

    // Directed command bytes, then random ones
    good_frame(8'hED);
    good_frame(8'hF4);
    good_frame(8'h00);
    good_frame(8'hFF);
    for (int i = 0; i < 4; i++) begin
      b = 8'($urandom_range(0, 255));
      good_frame(b);
    end

    // Ack missing on every attempt
    b  = 8'($urandom_range(0, 255));
    ph = inh_phases;
    for (int a = 0; a < ATTEMPTS; a++) exp_push(b, 10, 1'b0);
    exp_res.push_back(2'b01);
    send(b);
    dev_run(ATTEMPTS, 10, 0);
    wait_results();
    check("nack_phases", inh_phases - ph, ATTEMPTS);

`ifdef PS2_TX_RETRY_EN
    // Ack good on the second attempt
    b  = 8'($urandom_range(0, 255));
    ph = inh_phases;
    exp_push(b, 10, 1'b0);
    exp_push(b, 10, 1'b1);
    exp_res.push_back(2'b10);
    send(b);
    dev_run(2, 10, 2);
    wait_results();
    check("retry_phases", inh_phases - ph, 2);
`endif

    // Device stops clocking after 4 edges; tx_valid mid-frame is ignored
    b  = 8'($urandom_range(0, 255));
    ph = inh_phases;
    for (int a = 0; a < ATTEMPTS; a++) exp_push(b, 4, 1'b0);
    exp_res.push_back(2'b01);
    send(b);
    fork
      dev_run(ATTEMPTS, 4, 0);
      begin
        repeat (60) @(negedge clk);
        tx_data  = 8'($urandom_range(0, 255));
        tx_valid = 1'b1;
        repeat (10) @(negedge clk);
        tx_valid = 1'b0;
      end
    join
    cnt = 20;
    while (!tx_err && cnt < 400) begin @(negedge clk); cnt++; end
    check("timeout_window", int'(cnt >= 201 && cnt <= 205), 1);
    wait_results();
    check("timeout_phases", inh_phases - ph, ATTEMPTS);
    check("timeout_idle", int'({tx_ready, ps2_clk_oe}), 2);

    // Asynchronous reset while bit 5 is on the line
    exp_push(8'h1E, 6, 1'b0);
    send(8'h1E);
    dev_run(1, 6, 0);
    @(negedge clk);
    check("pre_rst_data_oe", int'(ps2_data_oe), 1);
    #2 rst = 1'b1;
    #1;
    check("rst_async_oe", int'({ps2_clk_oe, ps2_data_oe}), 0);
    check("rst_async_ready", int'({tx_ready, tx_busy}), 2);
    repeat (3) @(negedge clk);
    rst = 1'b0;
    repeat (300) @(negedge clk);
    check("post_rst_idle", int'({tx_ready, ps2_clk_oe, ps2_data_oe}), 4);
    exp_bits.delete();

    // Normal operation resumes after reset
    good_frame(8'hF4);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule

// File: doc/ps2_host_tx.md
Name: ps2_host_tx

Overview:
- Host-to-device PS/2 transmitter; the opposite direction of the keyboard receiver path.
- Sends command bytes such as 0xED (set LEDs), 0xF4 (enable) and 0xFF (reset) to the keyboard.
- Drives the open-collector clock and data lines through active-high pull-low enables and follows the device-generated clock.
- Sits beside the receiver on the same PS/2 pins. `tx_busy` tells the receiver to ignore line activity while a command frame is in flight.

Parameters:
- INHIBIT_CYCLES, 5000: system clocks the host holds ps2_clk low before the request (100 us at 50 MHz).
- TIMEOUT_CYCLES, 750000: maximum system clocks between consecutive device clock falling edges, or waiting for line idle (15 ms at 50 MHz).
- MAX_RETRIES, 2: extra attempts after a failed frame; used only with PS2_TX_RETRY_EN.

Ports:
- clk  input  1  system clock
- rst  input  1  asynchronous, active-high reset
- ps2_clk_in  input  1  raw PS/2 clock line level
- ps2_data_in  input  1  raw PS/2 data line level
- ps2_clk_oe  output  1  1 = pull PS/2 clock low; 0 = release
- ps2_data_oe  output  1  1 = pull PS/2 data low; 0 = release
- tx_data  input  8  command byte
- tx_valid  input  1  request to send tx_data
- tx_ready  output  1  high in IDLE only
- tx_busy  output  1  high in every state except IDLE
- tx_done  output  1  one-cycle pulse: frame acknowledged by the device
- tx_err  output  1  one-cycle pulse: ack missing or timeout

Behaviour:
- Reset: asynchronous and active-high, with immediate effect. State goes to IDLE. ps2_clk_oe=0, ps2_data_oe=0, tx_ready=1, tx_busy=0, tx_done=0, tx_err=0. Counters and synchronizers clear (synchronizers reset to 1).
- Reset mid-frame: both lines are released at once and no done or err pulse is issued.
- Synchronization: ps2_clk_in and ps2_data_in each pass through 2 flops.
- Falling edge: previous synchronized clock = 1 and current = 0. Edge detection adds 3 clocks of latency from the pin.
- Accept: tx_valid && tx_ready in IDLE.
  - Latch the frame: bits 0-7 = tx_data (LSB first), bit 8 = odd parity (~^tx_data), bit 9 = stop = 1.
  - Go to INHIBIT on the next clock.
  - tx_valid while not ready is ignored; there is no queue.
- INHIBIT: ps2_clk_oe=1 for exactly INHIBIT_CYCLES clocks, then go to REQ.
- REQ (1 cycle): ps2_clk_oe=1 and ps2_data_oe=1 (start bit 0). Next cycle: ps2_clk_oe=0, ps2_data_oe stays 1. Go to SEND with bit_idx=0.
- SEND:
  - On each falling edge, set ps2_data_oe = ~frame[bit_idx] and increment bit_idx.
  - After the edge that presents bit 9 (stop), go to ACK with ps2_data_oe=0.
  - Falling edges are ignored in INHIBIT and REQ.
- ACK:
  - On the next falling edge, sample synchronized data.
  - 0 = ack good: go to IDLE_WAIT.
  - 1 = ack missing: fail.
- IDLE_WAIT:
  - Wait until synchronized clock and data are both 1.
  - Then pulse tx_done for 1 cycle and return to IDLE (tx_ready=1 on the same cycle as tx_done).
- Timeout:
  - The watchdog clears on entry to SEND and on every falling edge.
  - In SEND, ACK or IDLE_WAIT, reaching TIMEOUT_CYCLES means fail.
- Fail (ack missing or timeout): release both lines, pulse tx_err for 1 cycle, go to IDLE.
- Simultaneous events: a falling edge on the same cycle the timeout reaches terminal count counts as the edge; no failure.
- Widths: the watchdog counter is $clog2(TIMEOUT_CYCLES+1) bits; bit_idx is 4 bits and never wraps (maximum value 10).
- Line ownership: the block never drives either line high; 0 in the enable means released.

Optional Feature:
- Macro: PS2_TX_RETRY_EN.
- Defined:
  - Fail does not pulse tx_err. The block re-enters INHIBIT with the same latched frame, up to MAX_RETRIES extra attempts.
  - tx_err pulses only after the final attempt fails.
  - A retry count of 0 behaves as the no-macro case.
  - tx_busy stays high across retries.
  - The retry counter clears on accept and on rst.
- Undefined: the first failure pulses tx_err immediately; MAX_RETRIES is unused.

Test Plan:
- Bench settings: INHIBIT_CYCLES=20, TIMEOUT_CYCLES=200, device model clock period 40 clocks.
- Send 0xED, device acks -> ps2_clk_oe low 20 cycles, then start bit. Data line per edge: 1,0,1,1,0,1,1,1, parity 1, stop 1. tx_done pulses once after line idle; tx_err stays 0.
- Send 0xF4 and 0x00 -> parity bit 0 for 0xF4 and 1 for 0x00. Both complete with tx_done.
- Device holds data high at the ack edge (macro off) -> tx_err pulses 1 cycle, both oe=0, tx_ready=1, no tx_done.
- Device stops clocking after 4 edges -> tx_err 200 cycles after the last edge, both lines released. tx_valid raised during the frame is ignored.
- rst asserted mid-SEND at bit 5 -> ps2_clk_oe and ps2_data_oe go 0 immediately (asynchronous); tx_ready=1, no pulses.
- PS2_TX_RETRY_EN, MAX_RETRIES=2, ack missing on every attempt -> 3 INHIBIT phases observed, then a single tx_err. With ack good on attempt 2 -> tx_done only, no tx_err.
